// File: rtl/lms_weight_update_n.sv
// Complex LMS weight-update engine: one channel per cycle through a
// shared complex multiplier, w_k <= sat(w_k + 2^-mu * e * conj(x_k)).
module lms_weight_update_n #(
  parameter int N_CH = 4,
  parameter int W    = 18,
  parameter int FRAC = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_CH*W-1:0] x_i,
  input  logic [N_CH*W-1:0] x_q,
  input  logic [W-1:0]      e_i,
  input  logic [W-1:0]      e_q,
  input  logic [4:0]        mu_shift,
  input  logic              freeze,
  output logic              out_valid,
  output logic [N_CH*W-1:0] w_i,
  output logic [N_CH*W-1:0] w_q,
  output logic              sat_flag
);

  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PW = 2*W + 2;
  localparam logic [CW-1:0] LAST = CW'(N_CH - 1);
  localparam logic signed [PW-1:0] SMAX =
    PW'((64'sd1 <<< (W - 1)) - 64'sd1);
  localparam logic signed [PW-1:0] SMIN = ~SMAX;
  localparam logic signed [W-1:0] ONE = W'(64'sd1 <<< FRAC);

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    DONE
  } state_t;

  state_t state, state_nx;
  logic [CW-1:0] ch;
  logic [N_CH*W-1:0] xi_r, xq_r;
  logic signed [W-1:0] ei_r, eq_r;
  logic [4:0] mu_r, mu_c;
  logic frz_r, acc, accept;
  logic signed [W-1:0] wi [N_CH];
  logic signed [W-1:0] wq [N_CH];

  assign in_ready = (state == IDLE) && !out_valid;
  assign accept   = in_valid && in_ready;
  assign mu_c     = (mu_shift > 5'd16) ? 5'd16 : mu_shift;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = UPDATE;
      UPDATE:  if (ch == LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Shared complex multiply for the selected channel
  logic signed [W-1:0] xs_i, xs_q, wc_i, wc_q;
  logic signed [PW-1:0] ei_x, eq_x, xi_x, xq_x;
  logic signed [PW-1:0] p_re, p_im, s_re, s_im;
  logic [6:0] sh;
  logic ovf_re, unf_re, ovf_im, unf_im, sat_now;
  logic signed [W-1:0] nw_i, nw_q;

  assign xs_i = $signed(xi_r[int'(ch)*W +: W]);
  assign xs_q = $signed(xq_r[int'(ch)*W +: W]);
  assign wc_i = wi[ch];
  assign wc_q = wq[ch];
  assign ei_x = PW'(ei_r);
  assign eq_x = PW'(eq_r);
  assign xi_x = PW'(xs_i);
  assign xq_x = PW'(xs_q);
  assign p_re = ei_x * xi_x + eq_x * xq_x;
  assign p_im = eq_x * xi_x - ei_x * xq_x;
  assign sh   = 7'(FRAC) + {2'b00, mu_r};
  assign s_re = PW'(wc_i) + (p_re >>> sh);
  assign s_im = PW'(wc_q) + (p_im >>> sh);
  assign ovf_re = s_re > SMAX;
  assign unf_re = s_re < SMIN;
  assign ovf_im = s_im > SMAX;
  assign unf_im = s_im < SMIN;
  assign sat_now = ovf_re | unf_re | ovf_im | unf_im;
  assign nw_i = ovf_re ? W'(SMAX) : unf_re ? W'(SMIN) : W'(s_re);
  assign nw_q = ovf_im ? W'(SMAX) : unf_im ? W'(SMIN) : W'(s_im);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ch        <= '0;
      out_valid <= 1'b0;
      sat_flag  <= 1'b0;
      acc       <= 1'b0;
      xi_r      <= '0;
      xq_r      <= '0;
      ei_r      <= '0;
      eq_r      <= '0;
      mu_r      <= '0;
      frz_r     <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        wi[k] <= (k == 0) ? ONE : '0;
        wq[k] <= '0;
      end
    end else begin
      state     <= state_nx;
      out_valid <= (state == DONE);
      sat_flag  <= (state == DONE) && acc;
      if (accept) begin
        xi_r  <= x_i;
        xq_r  <= x_q;
        ei_r  <= $signed(e_i);
        eq_r  <= $signed(e_q);
        mu_r  <= mu_c;
        frz_r <= freeze;
        acc   <= 1'b0;
        ch    <= '0;
      end
      if (state == UPDATE) begin
        ch <= ch + 1'b1;
        if (!frz_r) begin
          wi[ch] <= nw_i;
          wq[ch] <= nw_q;
          if (sat_now) acc <= 1'b1;
        end
      end
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_pack
    assign w_i[k*W +: W] = wi[k];
    assign w_q[k*W +: W] = wq[k];
  end

endmodule

// File: tb/tb_lms_weight_update_n.sv
// Bench for lms_weight_update_n: directed and random samples checked
// against an integer model of the complex LMS update.
module tb_lms_weight_update_n;

  localparam int N_CH = 4;
  localparam int W    = 18;
  localparam int FRAC = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [N_CH*W-1:0] x_i = '0, x_q = '0;
  logic [W-1:0] e_i = '0, e_q = '0;
  logic [4:0] mu_shift = '0;
  logic freeze = 1'b0;
  logic out_valid;
  logic [N_CH*W-1:0] w_i, w_q;
  logic sat_flag;

  lms_weight_update_n #(.N_CH(N_CH), .W(W), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .x_i(x_i), .x_q(x_q), .e_i(e_i), .e_q(e_q),
    .mu_shift(mu_shift), .freeze(freeze),
    .out_valid(out_valid), .w_i(w_i), .w_q(w_q),
    .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  longint mw_i [N_CH];
  longint mw_q [N_CH];
  longint nw_i [N_CH];
  longint nw_q [N_CH];
  bit     msat;
  int     xi_v [N_CH];
  int     xq_v [N_CH];

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic longint floordiv(longint p, int sh);
    longint d, q;
    d = 64'sd1 <<< sh;
    q = p / d;
    if ((p % d != 0) && (p < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint clampw(longint v, ref bit s);
    longint mx, mn;
    mx = (64'sd1 <<< (W - 1)) - 1;
    mn = -(64'sd1 <<< (W - 1));
    if (v > mx) begin s = 1; return mx; end
    if (v < mn) begin s = 1; return mn; end
    return v;
  endfunction

  function automatic int sgn(int unsigned v);
    int r;
    r = int'(v);
    if (v >= (1 << (W - 1))) r = r - (1 << W);
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N_CH; k++) begin
      mw_i[k] = (k == 0) ? (64'sd1 <<< FRAC) : 0;
      mw_q[k] = 0;
    end
  endtask

  task automatic model_step(int ei, int eq, int mu, bit frz);
    int sh;
    longint pr, pi;
    bit s;
    sh = FRAC + ((mu > 16) ? 16 : mu);
    msat = 0;
    for (int k = 0; k < N_CH; k++) begin
      pr = longint'(ei) * xi_v[k] + longint'(eq) * xq_v[k];
      pi = longint'(eq) * xi_v[k] - longint'(ei) * xq_v[k];
      s = 0;
      nw_i[k] = clampw(mw_i[k] + floordiv(pr, sh), s);
      nw_q[k] = clampw(mw_q[k] + floordiv(pi, sh), s);
      if (frz) begin
        nw_i[k] = mw_i[k];
        nw_q[k] = mw_q[k];
      end else if (s) begin
        msat = 1;
      end
    end
  endtask

  task automatic check_weights(string tag);
    logic [W-1:0] ei, eq;
    for (int k = 0; k < N_CH; k++) begin
      ei = mw_i[k][W-1:0];
      eq = mw_q[k][W-1:0];
      check($sformatf("%s_wi%0d", tag, k), 64'(w_i[k*W +: W]), 64'(ei));
      check($sformatf("%s_wq%0d", tag, k), 64'(w_q[k*W +: W]), 64'(eq));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic wait_ready(string tag);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_to"}, 64'(in_ready), 64'd1);
  endtask

  task automatic present(int ei, int eq, int mu, bit frz);
    for (int k = 0; k < N_CH; k++) begin
      x_i[k*W +: W] = xi_v[k][W-1:0];
      x_q[k*W +: W] = xq_v[k][W-1:0];
    end
    e_i = ei[W-1:0];
    e_q = eq[W-1:0];
    mu_shift = mu[4:0];
    freeze = frz;
  endtask

  task automatic scramble();
    x_i = {$urandom, $urandom, $urandom};
    x_q = {$urandom, $urandom, $urandom};
    e_i = W'($urandom);
    e_q = W'($urandom);
    mu_shift = 5'($urandom);
    freeze = ~freeze;
  endtask

  task automatic run(string tag, int ei, int eq, int mu, bit frz,
                     bit inject);
    logic [W-1:0] ew;
    wait_ready(tag);
    present(ei, eq, mu, frz);
    in_valid = 1'b1;
    model_step(ei, eq, mu, frz);
    @(negedge clk);
    in_valid = 1'b0;
    scramble();
    for (int k = 1; k <= N_CH + 1; k++) begin
      if (inject && k <= 2) in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      if (k <= N_CH) begin
        ew = nw_i[k-1][W-1:0];
        check($sformatf("%s_ch%0d_wi", tag, k - 1),
              64'(w_i[(k-1)*W +: W]), 64'(ew));
        check($sformatf("%s_ov_early%0d", tag, k), 64'(out_valid), 64'd0);
      end
    end
    for (int k = 0; k < N_CH; k++) begin
      mw_i[k] = nw_i[k];
      mw_q[k] = nw_q[k];
    end
    check({tag, "_ov"}, 64'(out_valid), 64'd1);
    check({tag, "_sat"}, 64'(sat_flag), 64'(msat));
    check({tag, "_busy"}, 64'(in_ready), 64'd0);
    check_weights(tag);
    @(negedge clk);
    check({tag, "_ov_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_rdy_back"}, 64'(in_ready), 64'd1);
  endtask

  task automatic quiet(string tag, int n);
    int pulses;
    pulses = 0;
    repeat (n) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    check({tag, "_no_ov"}, 64'(pulses), 64'd0);
  endtask

  task automatic fill(int a, int b);
    for (int k = 0; k < N_CH; k++) begin
      xi_v[k] = a;
      xq_v[k] = b;
    end
  endtask

  initial begin
    do_reset();
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_ov", 64'(out_valid), 64'd0);
    check("rst_sat", 64'(sat_flag), 64'd0);
    check("rst_w0", 64'(w_i[W-1:0]), 64'd32768);
    check_weights("rst");

    fill(32768, 0);
    run("basic", 32768, 0, 9, 1'b0, 1'b0);
    check("basic_w1", 64'(w_i[2*W-1:W]), 64'd64);

    do_reset();
    fill(0, 32768);
    run("imag", 32768, 0, 9, 1'b0, 1'b0);

    fill(-1, 0);
    run("floor", 1, 0, 0, 1'b0, 1'b0);

    fill(131071, 0);
    run("sat", 131071, 0, 0, 1'b0, 1'b0);
    check("sat_w3", 64'(w_i[4*W-1:3*W]), 64'd131071);
    run("frz", 131071, 0, 0, 1'b1, 1'b0);

    do_reset();
    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < N_CH; k++) begin
        xi_v[k] = sgn($urandom_range(0, (1 << W) - 1));
        xq_v[k] = sgn($urandom_range(0, (1 << W) - 1));
      end
      run($sformatf("rnd%0d", r),
          sgn($urandom_range(0, (1 << W) - 1)),
          sgn($urandom_range(0, (1 << W) - 1)),
          int'($urandom_range(0, 31)),
          ($urandom_range(0, 3) == 0), 1'b0);
    end

    fill(20000, -7000);
    run("hs", -15000, 9000, 3, 1'b0, 1'b1);
    quiet("hs", N_CH + 3);
    check_weights("hs_after");

    fill(30000, 30000);
    wait_ready("mid");
    present(30000, -30000, 0, 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("mid_ov", 64'(out_valid), 64'd0);
    check("mid_ready", 64'(in_ready), 64'd1);
    check_weights("mid");
    quiet("mid", N_CH + 3);
    check_weights("mid_after");

    fill(1000, -2000);
    run("post", 5000, 6000, 2, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lms_weight_update_n.md
# lms_weight_update_n

Parametrised complex LMS weight-update engine for the adaptive digital beamformer. It holds N_CH complex weights and, per accepted sample, applies w_k ← sat(w_k + μ·e·conj(x_k)) to every channel, with μ = 2^-mu_shift. It sits between the error generator and the beamforming combiner. A single time-multiplexed complex multiplier processes one channel per cycle, replacing fixed 4-channel per-channel multiplier arrays.

## Interface
- N_CH, 4: number of array channels/weights (≥1)
- W, 18: signed two's-complement width of every I/Q sample, error and weight
- FRAC, 15: fractional bits of the fixed-point format (1.0 = 2^FRAC)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  x/e/mu_shift/freeze valid this cycle
- in_ready  out  1  engine idle, can accept a sample
- x_i, x_q  in  N_CH*W  packed channel samples, channel k at bits [k*W +: W]
- e_i, e_q  in  W  common complex error
- mu_shift  in  5  step-size exponent; values >16 treated as 16
- freeze  in  1  1 = run sequence but leave weights unchanged
- out_valid  out  1  one-cycle pulse: full weight set updated
- w_i, w_q  out  N_CH*W  packed registered weights, same packing as x
- sat_flag  out  1  valid with out_valid: any channel saturated in this update

## Operation
- Reset: w_i[ch0] = 2^FRAC, all other w_i/w_q = 0; in_ready=1, out_valid=0, sat_flag=0; FSM → IDLE; channel counter = 0.
- FSM states: IDLE → UPDATE → DONE → IDLE.
  - IDLE: in_ready=1. On in_valid, capture x, e, clamped mu_shift and freeze into input registers; clear the internal saturation accumulator; go to UPDATE with ch=0.
  - UPDATE: in_ready=0. Each cycle processes channel ch and increments ch. After ch = N_CH-1, go to DONE.
  - DONE: out_valid=1 and sat_flag=accumulator for exactly one cycle; then IDLE.
- Per-channel arithmetic, on captured values:
  - p_re = e_i·x_i + e_q·x_q
  - p_im = e_q·x_i − e_i·x_q
  - Products use full precision (2W+1 bits).
  - d = p >>> (FRAC + mu_shift): arithmetic shift, floor rounding, so −1 >>> n = −1.
  - s = w + d, evaluated at sufficient width, then clamped to [−2^(W−1), 2^(W−1)−1].
  - If clamping occurred on either I or Q, set the accumulator.
  - If freeze=1, the weight write is suppressed and the accumulator is not set.
- Only weight ch changes in a given UPDATE cycle; w outputs are registered and reflect each channel's write on the following cycle.
- in_valid while in_ready=0 is ignored. No queuing; upstream must hold or drop.
- rst in any state, including mid-UPDATE, overrides everything: weights reinitialise, no out_valid pulse, partial update discarded.

## Timing
- Sample accepted at edge T0 (in_valid & in_ready).
- Channel k weight visible on w outputs after edge T0+1+k.
- out_valid=1 during cycle T0+N_CH+1 (after edge T0+N_CH+1). All weights final by then.
- in_ready=1 again from cycle T0+N_CH+2. Throughput is one sample per N_CH+2 cycles.
- mu_shift/freeze/x/e are sampled only at the accept edge; later changes have no effect on the current update.

## Test plan
- Reset check: assert rst 2 cycles → w_i ch0 = 32768, all other w = 0, in_ready=1, out_valid=0.
- Basic update (defaults): x_k=(32768,0) for all k, e=(32768,0), mu_shift=9 → out_valid at T0+5; w_i = {32832,64,64,64}, w_q all 0, sat_flag=0.
- Imaginary path: from reset, x_k=(0,32768), e=(32768,0), mu_shift=9 → all w_q = −64, w_i unchanged, sat_flag=0.
- Floor rounding: e=(1,0), x_k=(−1,0), mu_shift=0 → each w_i decreases by exactly 1.
- Saturation and freeze:
  - e=(131071,0), x_k=(131071,0), mu_shift=0 → all w_i = 131071, sat_flag=1.
  - Repeat with freeze=1 → weights unchanged, sat_flag=0, out_valid still pulses.
- Handshake and reset mid-op: pulse in_valid during UPDATE → ignored (single out_valid pulse). Assert rst at T0+2 → no out_valid, weights return to reset values, in_ready=1 the cycle after rst drops.
